// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: shared types and constants for the UART-side controllers
package uart_ctrl_pkg;
  localparam int UART_DATA_W = 8;
  typedef enum logic [1:0] {ARB_IDLE, ARB_SEND, ARB_GAP} arb_state_e;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin select, first set bit of req scanning from ptr upward with wrap
//   req: request mask, ptr: highest-priority index, win: one-hot winner, win_idx: winner index, any: req != 0
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         win,
  output logic [$clog2(N)-1:0] win_idx,
  output logic                 any
);
  always_comb begin
    win_idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) win_idx = $clog2(N)'((int'(ptr) + k) % N);
    any = |req;
    win = '0;
    win[win_idx] = any;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_master transmitter among NUM_REQ requesters
//   clk, rst_n (sync, active low); req/req_data: requester side; gnt/done: per-requester pulses;
//   tx_data/tx_en/tx_done: uart_master side; busy: not idle; timeout_err: watchdog abort pulse.
//   UART_ARB_TIMEOUT_EN enables the SEND watchdog (TIMEOUT_CYC cycles); otherwise timeout_err is 0.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = UART_DATA_W,
  parameter int TIMEOUT_CYC = 2048
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_en,
  input  logic                      tx_done,
  output logic                      busy,
  output logic                      timeout_err
);
  localparam int IW = $clog2(NUM_REQ);
  arb_state_e state, state_d;
  logic [IW-1:0] ptr, ptr_d, idx, idx_d, win_idx;
  logic [NUM_REQ-1:0] win, gnt_d, done_d;
  logic [DATA_W-1:0] tx_data_d;
  logic any, tx_en_d, grant, leave, finish, abort;
  rr_pick #(.N(NUM_REQ)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx),
    .any     (any)
  );
  assign finish = state == ARB_SEND && tx_done;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC);
  logic [WW-1:0] wd;
  // wd sits at 0 outside SEND, so it starts from 0 on every entry to SEND
  always_ff @(posedge clk)
    if (!rst_n) begin
      wd <= '0;
      timeout_err <= 1'b0;
    end else begin
      wd <= state == ARB_SEND ? wd + 1'b1 : '0;
      timeout_err <= abort;
    end
  assign abort = state == ARB_SEND && !tx_done && wd == WW'(TIMEOUT_CYC - 1);
`else
  assign abort = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= ARB_IDLE;
      ptr <= '0;
      idx <= '0;
      gnt <= '0;
      done <= '0;
      tx_data <= '0;
      tx_en <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_d;
      ptr <= ptr_d;
      idx <= idx_d;
      gnt <= gnt_d;
      done <= done_d;
      tx_data <= tx_data_d;
      tx_en <= tx_en_d;
      busy <= state_d != ARB_IDLE;
    end
  always_comb
    state_d = state == ARB_IDLE ? (any ? ARB_SEND : ARB_IDLE)
            : state == ARB_SEND ? (finish || abort ? ARB_GAP : ARB_SEND)
            : ARB_IDLE;
  always_comb begin
    grant = state == ARB_IDLE && any;
    leave = finish || abort;
    gnt_d = grant ? win : '0;
    done_d = finish ? NUM_REQ'(1) << idx : '0;
    tx_data_d = grant ? req_data[int'(win_idx)*DATA_W +: DATA_W] : tx_data;
    tx_en_d = grant || (state == ARB_SEND && !leave);
    idx_d = grant ? win_idx : idx;
    ptr_d = leave ? (idx == IW'(NUM_REQ - 1) ? '0 : idx + 1'b1) : ptr;
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: self-checking bench for uart_tx_arbiter with a uart_master tx_done model
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [7:0] dat [4];
  logic [31:0] req_data;
  logic [3:0] gnt, done;
  logic [7:0] tx_data;
  logic tx_en, busy, timeout_err;
  logic tx_done = 1'b0;
  logic prev_en = 1'b0;
  bit uart_on = 1'b1;
  int ucnt = 0;
  int total = 0;
  int bad = 0;

  assign req_data = {dat[3], dat[2], dat[1], dat[0]};

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT_CYC(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .done        (done),
    .tx_data     (tx_data),
    .tx_en       (tx_en),
    .tx_done     (tx_done),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // uart_master stand-in: one-cycle tx_done pulse 10 clocks after tx_en rises
  always @(negedge clk) begin
    tx_done = 1'b0;
    if (!rst_n || !uart_on) ucnt = 0;
    else if (tx_en && !prev_en) ucnt = 1;
    else if (ucnt > 0) ucnt++;
    if (ucnt == 10) begin
      tx_done = 1'b1;
      ucnt = 0;
    end
    prev_en = tx_en;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  function automatic int pick(logic [3:0] m, int p);
    for (int k = 0; k < 4; k++) if (m[(p + k) % 4]) return (p + k) % 4;
    return 0;
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    int c;
    rst_n = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) dat[i] = 8'(8'hA0 + i);
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if ({gnt, done, tx_data, tx_en, busy, timeout_err} !== '0) begin
        bad++;
        $display("FAIL reset_outputs gnt=%b done=%b tx_data=%h tx_en=%b busy=%b to=%b expected all 0",
                 gnt, done, tx_data, tx_en, busy, timeout_err);
      end
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (gnt !== 4'b0001 || tx_data !== 8'hA0) begin
      bad++;
      $display("FAIL reset_first_grant gnt=%b tx_data=%h expected 0001/a0", gnt, tx_data);
    end
    req = '0;
    c = 0;
    while (done === '0 && c < 40) begin tick(); c++; end
    total++;
    if (done !== 4'b0001) begin
      bad++;
      $display("FAIL reset_first_done done=%b expected 0001", done);
    end
  endtask

  task automatic test_single;
    int n, c;
    do_reset();
    dat[2] = 8'h95;
    req = 4'b0100;
    tick();
    total++;
    if (gnt !== 4'b0100 || tx_en !== 1'b1 || tx_data !== 8'h95 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_grant gnt=%b tx_en=%b tx_data=%h busy=%b expected 0100/1/95/1", gnt, tx_en, tx_data, busy);
    end
    req = '0;
    n = 0;
    c = 0;
    while (done === '0 && c < 40) begin
      if (tx_en === 1'b1) n++;
      total++;
      if (tx_data !== 8'h95) begin
        bad++;
        $display("FAIL single_data_hold tx_data=%h expected 95", tx_data);
      end
      tick();
      c++;
    end
    total++;
    if (done !== 4'b0100 || tx_en !== 1'b0 || busy !== 1'b1 || gnt !== '0 || n != 10) begin
      bad++;
      $display("FAIL single_done done=%b tx_en=%b busy=%b gnt=%b en_cycles=%0d expected 0100/0/1/0000/10",
               done, tx_en, busy, gnt, n);
    end
    tick();
    total++;
    if (done !== '0 || tx_en !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_gap done=%b tx_en=%b busy=%b expected 0000/0/0", done, tx_en, busy);
    end
  endtask

  task automatic test_round_robin;
    int c;
    do_reset();
    for (int i = 0; i < 4; i++) dat[i] = 8'(8'hA0 + i);
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      c = 0;
      while (gnt === '0 && c < 40) begin tick(); c++; end
      total++;
      if (gnt !== 4'(4'b1 << (t % 4)) || tx_data !== 8'(8'hA0 + t % 4)) begin
        bad++;
        $display("FAIL rr_grant_%0d gnt=%b tx_data=%h expected %b/%h", t, gnt, tx_data,
                 4'(4'b1 << (t % 4)), 8'(8'hA0 + t % 4));
      end
      c = 0;
      while (done === '0 && c < 40) begin tick(); c++; end
      total++;
      if (done !== 4'(4'b1 << (t % 4))) begin
        bad++;
        $display("FAIL rr_done_%0d done=%b expected %b", t, done, 4'(4'b1 << (t % 4)));
      end
    end
    req = '0;
  endtask

  task automatic test_data_latch;
    int c;
    do_reset();
    dat[1] = 8'h3C;
    req = 4'b0010;
    c = 0;
    while (gnt === '0 && c < 10) begin tick(); c++; end
    total++;
    if (gnt !== 4'b0010 || tx_data !== 8'h3C) begin
      bad++;
      $display("FAIL latch_grant gnt=%b tx_data=%h expected 0010/3c", gnt, tx_data);
    end
    dat[1] = 8'hFF;
    req = '0;
    c = 0;
    while (done === '0 && c < 40) begin
      tick();
      c++;
      total++;
      if (tx_data !== 8'h3C) begin
        bad++;
        $display("FAIL latch_hold tx_data=%h expected 3c", tx_data);
      end
    end
    total++;
    if (done !== 4'b0010) begin
      bad++;
      $display("FAIL latch_done done=%b expected 0010", done);
    end
  endtask

  task automatic test_mid_reset;
    bit seen;
    do_reset();
    dat[0] = 8'h5A;
    req = 4'b0001;
    tick();
    req = '0;
    repeat (5) tick();
    total++;
    if (tx_en !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL midrst_sending tx_en=%b busy=%b expected 1/1", tx_en, busy);
    end
    rst_n = 1'b0;
    tick();
    total++;
    if (tx_en !== 1'b0 || busy !== 1'b0 || done !== '0) begin
      bad++;
      $display("FAIL midrst_drop tx_en=%b busy=%b done=%b expected 0/0/0000", tx_en, busy, done);
    end
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      tick();
      if (done !== '0 || tx_en !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL midrst_quiet activity=%b expected 0", seen);
    end
  endtask

  task automatic test_random;
    int c, w, mptr;
    logic [3:0] pend, add;
    do_reset();
    mptr = 0;
    pend = '0;
    for (int t = 0; t < 30; t++) begin
      add = 4'($urandom_range(0, 15));
      if ((pend | add) == '0) add = 4'(4'b1 << $urandom_range(0, 3));
      for (int i = 0; i < 4; i++) if (add[i] && !pend[i]) dat[i] = 8'($urandom);
      pend |= add;
      req = pend;
      w = pick(pend, mptr);
      c = 0;
      while (gnt === '0 && c < 40) begin tick(); c++; end
      total++;
      if (gnt !== 4'(4'b1 << w) || tx_data !== dat[w]) begin
        bad++;
        $display("FAIL rand_grant_%0d gnt=%b tx_data=%h expected %b/%h", t, gnt, tx_data, 4'(4'b1 << w), dat[w]);
      end
      pend[w] = 1'b0;
      req = pend;
      c = 0;
      while (done === '0 && c < 40) begin
        tick();
        c++;
        total++;
        if ((gnt & done) !== '0) begin
          bad++;
          $display("FAIL rand_overlap gnt=%b done=%b expected disjoint", gnt, done);
        end
      end
      total++;
      if (done !== 4'(4'b1 << w)) begin
        bad++;
        $display("FAIL rand_done_%0d done=%b expected %b", t, done, 4'(4'b1 << w));
      end
      mptr = (w + 1) % 4;
    end
    req = '0;
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout;
    int n, c;
    bit saw_done;
    do_reset();
    uart_on = 1'b0;
    dat[0] = 8'h11;
    dat[1] = 8'h22;
    req = 4'b0011;
    tick();
    total++;
    if (gnt !== 4'b0001) begin
      bad++;
      $display("FAIL to_grant gnt=%b expected 0001", gnt);
    end
    req = 4'b0010;
    n = 0;
    c = 0;
    saw_done = 1'b0;
    while (timeout_err !== 1'b1 && c < 40) begin
      if (tx_en === 1'b1) n++;
      if (done !== '0) saw_done = 1'b1;
      tick();
      c++;
    end
    total++;
    if (n != 16 || timeout_err !== 1'b1 || tx_en !== 1'b0 || done !== '0 || saw_done) begin
      bad++;
      $display("FAIL to_abort en_cycles=%0d to=%b tx_en=%b done=%b saw_done=%b expected 16/1/0/0000/0",
               n, timeout_err, tx_en, done, saw_done);
    end
    uart_on = 1'b1;
    c = 0;
    while (gnt === '0 && c < 10) begin tick(); c++; end
    total++;
    if (gnt !== 4'b0010 || tx_data !== 8'h22 || timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL to_next_grant gnt=%b tx_data=%h to=%b expected 0010/22/0", gnt, tx_data, timeout_err);
    end
    req = '0;
    c = 0;
    while (done === '0 && c < 40) begin tick(); c++; end
    total++;
    if (done !== 4'b0010) begin
      bad++;
      $display("FAIL to_next_done done=%b expected 0010", done);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 4; i++) dat[i] = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_data_latch();
    test_mid_reset();
    test_random();
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
